// File: rtl/switch_pkg.sv
// Shared definitions for the 2x2 switch packet arbiter: word layout, default
// port addresses and the per-output arbitration state.
package switch_pkg;

    localparam int DATA_W_DEF = 32;

    // Flag positions counted upward from the top of the data field.
    localparam int SOP_BIT = 0;
    localparam int EOP_BIT = 1;

    localparam logic [DATA_W_DEF-1:0] PORTA_ADDR_DEF = 32'hABCD;
    localparam logic [DATA_W_DEF-1:0] PORTB_ADDR_DEF = 32'h1234;

    typedef struct packed {
        logic                  eop;
        logic                  sop;
        logic [DATA_W_DEF-1:0] data;
    } word_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/switch_out_sched.sv
// Per-output scheduler: round-robin grant between two inputs, packet lock from
// SOP to EOP, and a registered valid/ready output word.
module switch_out_sched
    import switch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        in_valid,
    input  logic [DATA_W+1:0] in_word0,
    input  logic [DATA_W+1:0] in_word1,
    output logic [1:0]        pop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W+1:0] out_word,
    output logic              busy,
    output logic              owner
);

    arb_state_t        state_p0, state_nxt;
    logic              owner_p0, owner_nxt;
    logic              rr_p0, rr_nxt;
    logic              load;
    logic [DATA_W+1:0] head;
    logic              out_valid_p1;
    logic [DATA_W+1:0] out_word_p1;

    assign head = owner_p0 ? in_word1 : in_word0;

    always_comb begin
        state_nxt = state_p0;
        owner_nxt = owner_p0;
        rr_nxt    = rr_p0;
        pop       = '0;
        load      = 1'b0;
        case (state_p0)
            IDLE: begin
                if (req != 2'b00) begin
                    state_nxt = BUSY;
                    owner_nxt = (req == 2'b11) ? rr_p0 : req[1];
                end
            end
            BUSY: begin
                load          = in_valid[owner_p0] && (!out_valid_p1 || out_ready) && !rst;
                pop[owner_p0] = load;
                // The pointer only advances once a whole packet has left.
                if (load && head[DATA_W+EOP_BIT]) begin
                    state_nxt = IDLE;
                    rr_nxt    = !owner_p0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: arbitration state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= IDLE;
            owner_p0 <= 1'b0;
            rr_p0    <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            owner_p0 <= owner_nxt;
            rr_p0    <= rr_nxt;
        end
    end

    // Stage p1: registered output word
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_p1 <= 1'b0;
            out_word_p1  <= '0;
        end else if (load) begin
            out_valid_p1 <= 1'b1;
            out_word_p1  <= head;
        end else if (out_ready) begin
            out_valid_p1 <= 1'b0;
        end
    end

    assign out_valid = out_valid_p1;
    assign out_word  = out_word_p1;
    assign busy      = (state_p0 == BUSY);
    assign owner     = owner_p0;

endmodule

// File: rtl/switch_pkt_arbiter.sv
// 2x2 switch packet scheduler: destination decode, orphan-word discard and
// drop counting around two per-output schedulers.
module switch_pkt_arbiter
    import switch_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter logic [DATA_W-1:0] PORTA_ADDR = DATA_W'(PORTA_ADDR_DEF),
    parameter logic [DATA_W-1:0] PORTB_ADDR = DATA_W'(PORTB_ADDR_DEF),
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        in_valid,
    input  logic [DATA_W+1:0] in_word0,
    input  logic [DATA_W+1:0] in_word1,
    output logic [1:0]        in_pop,
    output logic [1:0]        out_valid,
    input  logic [1:0]        out_ready,
    output logic [DATA_W+1:0] out_word0,
    output logic [DATA_W+1:0] out_word1,
    output logic [1:0]        out_busy,
    output logic [1:0]        out_owner,
    output logic [CNT_W-1:0]  drop_cnt
);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    logic [1:0]        sop, dest_b, owned, orphan;
    logic [1:0]        req0, req1, pop0, pop1;
    logic [DATA_W-1:0] addr [2];

    assign sop     = {in_word1[DATA_W+SOP_BIT], in_word0[DATA_W+SOP_BIT]};
    assign addr[0] = in_word0[DATA_W-1:0];
    assign addr[1] = in_word1[DATA_W-1:0];

    // An input already locked to an output neither requests nor drops words.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            dest_b[i] = (addr[i] != PORTA_ADDR) && (addr[i] == PORTB_ADDR);
            owned[i]  = (out_busy[0] && (out_owner[0] == 1'(i))) ||
                        (out_busy[1] && (out_owner[1] == 1'(i)));
            req0[i]   = in_valid[i] && sop[i] && !owned[i] && !dest_b[i];
            req1[i]   = in_valid[i] && sop[i] && !owned[i] &&  dest_b[i];
            orphan[i] = in_valid[i] && !sop[i] && !owned[i] && !rst;
        end
    end

    assign in_pop = pop0 | pop1 | orphan;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (orphan != 2'b00) begin
            drop_cnt <= sat_add(drop_cnt, {1'b0, orphan[0]} + {1'b0, orphan[1]});
        end
    end

    switch_out_sched #(.DATA_W(DATA_W)) u_sched0 (
        .clk       (clk),
        .rst       (rst),
        .req       (req0),
        .in_valid  (in_valid),
        .in_word0  (in_word0),
        .in_word1  (in_word1),
        .pop       (pop0),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_word  (out_word0),
        .busy      (out_busy[0]),
        .owner     (out_owner[0])
    );

    switch_out_sched #(.DATA_W(DATA_W)) u_sched1 (
        .clk       (clk),
        .rst       (rst),
        .req       (req1),
        .in_valid  (in_valid),
        .in_word0  (in_word0),
        .in_word1  (in_word1),
        .pop       (pop1),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_word  (out_word1),
        .busy      (out_busy[1]),
        .owner     (out_owner[1])
    );

endmodule
